// File: rtl/seg_scan_master.sv
// Bus initiator that fetches a 16-bit value and multiplexes it onto a 4-digit 7-segment display register.
// Optional build macro BLANK_LEADING_ZERO_EN blanks leading zero digits 1..3.
module seg_scan_master #(
  parameter logic [31:0] SRC_ADDR = 32'h00000100,
  parameter logic [31:0] SEG_ADDR = 32'h40000010,
  parameter int          SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        Write_enable,
  output logic        Read_enable,
  output logic        WordorByte,
  output logic [31:0] Addr,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data,
  output logic [15:0] cur_value,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_RD,
    READ,
    REQ_WR,
    WRITE,
    WAIT_TICK
  } state_t;

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_t           state;
  state_t           state_next;
  logic [1:0]       digit_idx;
  logic [DIV_W-1:0] divider;
  logic             stop_pending;
  logic [3:0]       nibble;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic [6:0]       seg_raw;
  logic [15:0]      unused_rd_hi;

  assign unused_rd_hi = Read_data[31:16];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nibble = cur_value[3:0];
    an     = 4'b1110;
    case (digit_idx)
      2'd1: begin nibble = cur_value[7:4];   an = 4'b1101; end
      2'd2: begin nibble = cur_value[11:8];  an = 4'b1011; end
      2'd3: begin nibble = cur_value[15:12]; an = 4'b0111; end
      default: begin nibble = cur_value[3:0]; an = 4'b1110; end
    endcase
  end

  assign seg_raw = hex_to_seg(nibble);

`ifdef BLANK_LEADING_ZERO_EN
  logic lead_zero;

  // A digit is blank only when it and every more-significant digit are zero.
  always_comb begin
    lead_zero = 1'b0;
    case (digit_idx)
      2'd1: lead_zero = (cur_value[15:4] == 12'h000);
      2'd2: lead_zero = (cur_value[15:8] == 8'h00);
      2'd3: lead_zero = (cur_value[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end

  assign seg = lead_zero ? 7'h7F : seg_raw;
`else
  assign seg = seg_raw;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_next   = state;
    bus_req      = 1'b0;
    Read_enable  = 1'b0;
    Write_enable = 1'b0;
    WordorByte   = 1'b0;
    Addr         = 32'h0;
    Write_data   = 32'h0;
    case (state)
      IDLE: begin
        if (enable) state_next = REQ_RD;
      end
      REQ_RD: begin
        bus_req = 1'b1;
        if (bus_gnt) state_next = READ;
      end
      READ: begin
        bus_req     = 1'b1;
        Read_enable = 1'b1;
        WordorByte  = 1'b1;
        Addr        = SRC_ADDR;
        state_next  = REQ_WR;
      end
      REQ_WR: begin
        bus_req = 1'b1;
        if (bus_gnt) state_next = WRITE;
      end
      WRITE: begin
        bus_req      = 1'b1;
        Write_enable = 1'b1;
        WordorByte   = 1'b1;
        Addr         = SEG_ADDR;
        Write_data   = {20'b0, an, 1'b0, seg};
        state_next   = (stop_pending || !enable) ? IDLE : WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) state_next = IDLE;
        else if (divider == DIV_LAST) state_next = (digit_idx == 2'd0) ? REQ_RD : REQ_WR;
      end
      default: state_next = IDLE;
    endcase
  end

  // A stop request seen mid-transfer is remembered so the sweep still ends after its write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      digit_idx    <= 2'd0;
      divider      <= '0;
      stop_pending <= 1'b0;
      cur_value    <= 16'h0;
    end else begin
      state <= state_next;
      if (state == READ) cur_value <= Read_data[15:0];
      if (state_next == IDLE) begin
        digit_idx    <= 2'd0;
        divider      <= '0;
        stop_pending <= 1'b0;
      end else begin
        if (state == WRITE) begin
          digit_idx <= digit_idx + 2'd1;
          divider   <= '0;
        end else if (state == WAIT_TICK) begin
          divider <= divider + 1'b1;
        end
        if (!enable && state != IDLE) stop_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_master.sv
// Self-checking bench for seg_scan_master: table-driven sweeps plus hand-written corner sequences.
// Expected digit patterns follow BLANK_LEADING_ZERO_EN when it is defined.
module tb_seg_scan_master;

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        bus_req;
  logic        bus_gnt;
  logic        Write_enable;
  logic        Read_enable;
  logic        WordorByte;
  logic [31:0] Addr;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic [15:0] cur_value;
  logic        busy;
  logic [15:0] mem_word;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] mem;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[20];

  seg_scan_master #(
    .SRC_ADDR(32'h00000100),
    .SEG_ADDR(32'h40000010),
    .SCAN_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .Write_enable(Write_enable),
    .Read_enable(Read_enable),
    .WordorByte(WordorByte),
    .Addr(Addr),
    .Write_data(Write_data),
    .Read_data(Read_data),
    .cur_value(cur_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Single data-memory word; anything else on the bus reads as all ones.
  assign Read_data = (Read_enable && Addr == 32'h00000100) ? {16'h0000, mem_word} : 32'hFFFF_FFFF;

  task automatic applyStimulus(input logic rst, input logic en, input logic gnt);
    reset   = rst;
    enable  = en;
    bus_gnt = gnt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic waitWrite(output logic [31:0] wdata, output logic [31:0] waddr, output int reads,
                           output logic [31:0] raddr, output logic [15:0] cv, output logic wb,
                           output bit ok);
    ok = 1'b0; reads = 0; raddr = '0; wdata = '0; waddr = '0; cv = '0; wb = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (Read_enable) begin
        reads++;
        raddr = Addr;
      end
      if (Write_enable) begin
        wdata = Write_data;
        waddr = Addr;
        cv    = cur_value;
        wb    = WordorByte;
        ok    = 1'b1;
        break;
      end
    end
  endtask

  task automatic doWrite(input string name, input int expReads, input logic [31:0] expData,
                         input logic [15:0] expVal);
    logic [31:0] wd, wa, ra;
    logic [15:0] cv;
    logic        wb;
    int          rd;
    bit          ok;
    waitWrite(wd, wa, rd, ra, cv, wb, ok);
    checkOutput({name, " write seen"}, 32'(ok), 32'd1);
    if (ok) begin
      checkOutput({name, " data"}, wd, expData);
      checkOutput({name, " addr"}, wa, 32'h40000010);
      checkOutput({name, " word"}, 32'(wb), 32'd1);
      checkOutput({name, " reads"}, 32'(rd), 32'(expReads));
      checkOutput({name, " cur_value"}, 32'(cv), 32'(expVal));
      if (expReads > 0) checkOutput({name, " read addr"}, ra, 32'h00000100);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit quiet;
    bit seen;

    vecs[0]  = '{16'h12AF, 32'h0000_0E0E};
    vecs[1]  = '{16'h12AF, 32'h0000_0D08};
    vecs[2]  = '{16'h12AF, 32'h0000_0B24};
    vecs[3]  = '{16'h12AF, 32'h0000_0779};
    vecs[4]  = '{16'h0005, 32'h0000_0E12};
    vecs[5]  = '{16'h0005, BLANK ? 32'h0000_0D7F : 32'h0000_0D40};
    vecs[6]  = '{16'h0005, BLANK ? 32'h0000_0B7F : 32'h0000_0B40};
    vecs[7]  = '{16'h0005, BLANK ? 32'h0000_077F : 32'h0000_0740};
    vecs[8]  = '{16'h3C00, 32'h0000_0E40};
    vecs[9]  = '{16'h3C00, 32'h0000_0D40};
    vecs[10] = '{16'h3C00, 32'h0000_0B46};
    vecs[11] = '{16'h3C00, 32'h0000_0730};
    vecs[12] = '{16'h00B0, 32'h0000_0E40};
    vecs[13] = '{16'h00B0, 32'h0000_0D03};
    vecs[14] = '{16'h00B0, BLANK ? 32'h0000_0B7F : 32'h0000_0B40};
    vecs[15] = '{16'h00B0, BLANK ? 32'h0000_077F : 32'h0000_0740};
    vecs[16] = '{16'h89D0, 32'h0000_0E40};
    vecs[17] = '{16'h89D0, 32'h0000_0D21};
    vecs[18] = '{16'h89D0, 32'h0000_0B10};
    vecs[19] = '{16'h89D0, 32'h0000_0700};

    // Reset state.
    mem_word = 16'h12AF;
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset strobes", {30'd0, Write_enable, Read_enable}, 32'd0);
    checkOutput("reset addr", Addr, 32'd0);
    checkOutput("reset wdata", Write_data, 32'd0);
    checkOutput("reset cur_value", 32'(cur_value), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("idle while disabled", 32'(busy), 32'd0);

    // Table-driven sweeps; digit-0 slots must re-read the source word first.
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_word = vecs[i].mem;
      doWrite($sformatf("vec%0d", i), (i % 4 == 0) ? 1 : 0, vecs[i].wdata, vecs[i].mem);
      if (i == 0) begin
        quiet = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (bus_req || Read_enable || Write_enable || !busy) quiet = 1'b0;
        end
        checkOutput("wait_tick quiet 4 cycles", 32'(quiet), 32'd1);
        @(negedge clk);
        checkOutput("wait_tick end bus_req", 32'(bus_req), 32'd1);
      end
    end

    // Grant withheld for 10 cycles in REQ_RD.
    bus_gnt  = 1'b0;
    mem_word = 16'h12AF;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus_req) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("req_rd reached", 32'(seen), 32'd1);
    quiet = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (!bus_req || Read_enable || Write_enable) quiet = 1'b0;
    end
    checkOutput("no grant holds request", 32'(quiet), 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    checkOutput("read after grant", 32'(Read_enable), 32'd1);
    checkOutput("read after grant addr", Addr, 32'h00000100);

    // Enable dropped during REQ_WR: the write still completes.
    @(negedge clk);
    checkOutput("req_wr state", {29'd0, bus_req, Write_enable, Read_enable}, 32'b100);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("stop write strobe", 32'(Write_enable), 32'd1);
    checkOutput("stop write data", Write_data, 32'h0000_0E0E);
    @(negedge clk);
    checkOutput("stop idle flags", {28'd0, busy, bus_req, Write_enable, Read_enable}, 32'd0);
    checkOutput("stop idle addr", Addr, 32'd0);
    checkOutput("stop idle wdata", Write_data, 32'd0);
    checkOutput("stop keeps cur_value", 32'(cur_value), 32'h12AF);
    repeat (3) @(negedge clk);
    checkOutput("stays idle", 32'(busy), 32'd0);

    // Restart from IDLE begins again at digit 0 with a fresh read.
    enable = 1'b1;
    doWrite("restart d0", 1, 32'h0000_0E0E, 16'h12AF);
    doWrite("restart d1", 0, 32'h0000_0D08, 16'h12AF);

    // Asynchronous reset in the middle of the WRITE cycle.
    #1 reset = 1'b0;
    #1;
    checkOutput("async reset write strobe", 32'(Write_enable), 32'd0);
    checkOutput("async reset flags", {29'd0, busy, bus_req, Read_enable}, 32'd0);
    checkOutput("async reset cur_value", 32'(cur_value), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    doWrite("post reset d0", 1, 32'h0000_0E0E, 16'h12AF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
